// File: rtl/tl45_pkg.sv
// Shared TL45 operand-fetch definitions: opcode constants, FSM states and the
// helper that tells which opcodes never claim their destination register.
package tl45_pkg;

    localparam logic [4:0] OPC_NOP = 5'h00;
    localparam logic [4:0] OPC_JMP = 5'h0C;
    localparam logic [4:0] OPC_LW  = 5'h15;

    typedef enum logic {
        RUN = 1'b0,
        HAZ = 1'b1
    } of_state_e;

    // Opcodes whose i_dr field must not mark a register busy at issue.
    function automatic logic ignore_dr(input logic [4:0] opc);
        return (opc == OPC_NOP) || (opc == OPC_JMP) || (opc == OPC_LW);
    endfunction

endpackage

// File: rtl/tl45_operand_resolve.sv
// Combinational resolution of one source operand: immediate, register file
// value when not busy, else the lowest-index matching forward bus.
module tl45_operand_resolve
    import tl45_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    parameter int NFWD  = 2,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic [REG_AW-1:0]      i_src,
    input  logic                   i_use_imm,
    input  logic [XLEN-1:0]        i_imm,
    input  logic [XLEN-1:0]        i_rf_data,
    input  logic [NREGS-2:0]       i_busylist,
    input  logic [NFWD-1:0]        i_fwd_valid,
    input  logic [NFWD*REG_AW-1:0] i_fwd_reg,
    input  logic [NFWD*XLEN-1:0]   i_fwd_data,
    output logic [XLEN-1:0]        o_value,
    output logic                   o_resolved
);

    // r0 is never busy, so slot 0 of the widened vector is tied low.
    logic [NREGS-1:0] busy_vec;
    assign busy_vec = {i_busylist, 1'b0};

    always_comb begin
        o_value    = '0;
        o_resolved = 1'b0;
        if (i_use_imm) begin
            o_value    = i_imm;
            o_resolved = 1'b1;
        end else if (!busy_vec[i_src]) begin
            o_value    = i_rf_data;
            o_resolved = 1'b1;
        end else begin
            // Scan downwards so the lowest matching bus is the last writer.
            for (int j = NFWD - 1; j >= 0; j--) begin
                if (i_fwd_valid[j] && (i_fwd_reg[j*REG_AW +: REG_AW] == i_src)) begin
                    o_value    = i_fwd_data[j*XLEN +: XLEN];
                    o_resolved = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tl45_operand_fetch.sv
// TL45 register-read stage: resolves operands, bubbles on hazards, claims dest.
// Define TL45_OPFETCH_PERF_EN to add the o_haz_cycles HAZ-cycle counter.
module tl45_operand_fetch
    import tl45_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    parameter int NFWD  = 2,
    parameter int OPC_W = 5,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_pipe_stall,
    output logic                   o_pipe_stall,
    input  logic                   i_pipe_flush,
    output logic                   o_pipe_flush,
    input  logic [OPC_W-1:0]       i_opcode,
    input  logic                   i_ri,
    input  logic [REG_AW-1:0]      i_dr,
    input  logic [REG_AW-1:0]      i_sr1,
    input  logic [REG_AW-1:0]      i_sr2,
    input  logic [XLEN-1:0]        i_imm,
    input  logic [XLEN-1:0]        i_pc,
    output logic [REG_AW-1:0]      o_dprf_read_a1,
    output logic [REG_AW-1:0]      o_dprf_read_a2,
    input  logic [XLEN-1:0]        i_dprf_d1,
    input  logic [XLEN-1:0]        i_dprf_d2,
    output logic [REG_AW-1:0]      o_dprf_setbusy,
    input  logic [NREGS-2:0]       i_dprf_busylist,
    input  logic [NFWD-1:0]        i_fwd_valid,
    input  logic [NFWD*REG_AW-1:0] i_fwd_reg,
    input  logic [NFWD*XLEN-1:0]   i_fwd_data,
    output logic [OPC_W-1:0]       o_opcode,
    output logic [REG_AW-1:0]      o_dr,
    output logic [XLEN-1:0]        o_sr1_val,
    output logic [XLEN-1:0]        o_sr2_val,
    output logic [XLEN-1:0]        o_pc,
`ifdef TL45_OPFETCH_PERF_EN
    output logic [31:0]            o_haz_cycles,
`endif
    output logic                   o_hazard
);

    logic [XLEN-1:0] src1_val, src2_val;
    logic            src1_ok, src2_ok;
    logic            need_haz;
    logic            issue;

    of_state_e         state_q,   state_d;
    logic [OPC_W-1:0]  opcode_q,  opcode_d;
    logic [REG_AW-1:0] dr_q,      dr_d;
    logic [XLEN-1:0]   sr1_val_q, sr1_val_d;
    logic [XLEN-1:0]   sr2_val_q, sr2_val_d;
    logic [XLEN-1:0]   pc_q,      pc_d;

    tl45_operand_resolve #(.XLEN(XLEN), .NREGS(NREGS), .NFWD(NFWD)) u_res1 (
        .i_src(i_sr1), .i_use_imm(1'b0), .i_imm(i_imm), .i_rf_data(i_dprf_d1),
        .i_busylist(i_dprf_busylist), .i_fwd_valid(i_fwd_valid),
        .i_fwd_reg(i_fwd_reg), .i_fwd_data(i_fwd_data),
        .o_value(src1_val), .o_resolved(src1_ok)
    );

    tl45_operand_resolve #(.XLEN(XLEN), .NREGS(NREGS), .NFWD(NFWD)) u_res2 (
        .i_src(i_sr2), .i_use_imm(i_ri), .i_imm(i_imm), .i_rf_data(i_dprf_d2),
        .i_busylist(i_dprf_busylist), .i_fwd_valid(i_fwd_valid),
        .i_fwd_reg(i_fwd_reg), .i_fwd_data(i_fwd_data),
        .o_value(src2_val), .o_resolved(src2_ok)
    );

    assign need_haz       = (i_opcode != '0) && !(src1_ok && src2_ok);
    assign o_pipe_stall   = i_pipe_stall | (need_haz && !i_pipe_flush);
    assign o_pipe_flush   = i_pipe_flush;
    assign o_dprf_read_a1 = i_sr1;
    assign o_dprf_read_a2 = i_sr2;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        dr_d      = dr_q;
        sr1_val_d = sr1_val_q;
        sr2_val_d = sr2_val_q;
        pc_d      = pc_q;
        issue     = 1'b0;
        if (i_pipe_flush) begin
            state_d   = RUN;
            opcode_d  = '0;
            dr_d      = '0;
            sr1_val_d = '0;
            sr2_val_d = '0;
            pc_d      = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!i_pipe_stall && need_haz) begin
                        state_d   = HAZ;
                        opcode_d  = '0;
                        dr_d      = '0;
                        sr1_val_d = '0;
                        sr2_val_d = '0;
                        pc_d      = '0;
                    end else if (!i_pipe_stall) begin
                        issue = 1'b1;
                    end
                end
                HAZ: begin
                    // Outputs already hold the bubble; only leave on a clean issue.
                    if (!need_haz && !i_pipe_stall) begin
                        state_d = RUN;
                        issue   = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
            if (issue) begin
                opcode_d  = i_opcode;
                dr_d      = i_dr;
                sr1_val_d = src1_val;
                sr2_val_d = src2_val;
                pc_d      = i_pc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= RUN;
            opcode_q  <= '0;
            dr_q      <= '0;
            sr1_val_q <= '0;
            sr2_val_q <= '0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            dr_q      <= dr_d;
            sr1_val_q <= sr1_val_d;
            sr2_val_q <= sr2_val_d;
            pc_q      <= pc_d;
        end
    end

    assign o_dprf_setbusy = (issue && !i_reset && !ignore_dr(5'(i_opcode))) ? i_dr : '0;

    assign o_opcode  = opcode_q;
    assign o_dr      = dr_q;
    assign o_sr1_val = sr1_val_q;
    assign o_sr2_val = sr2_val_q;
    assign o_pc      = pc_q;
    assign o_hazard  = (state_q == HAZ);

`ifdef TL45_OPFETCH_PERF_EN
    logic [31:0] haz_cycles_q, haz_cycles_d;

    // Saturating; flush deliberately does not clear it.
    always_comb begin
        haz_cycles_d = haz_cycles_q;
        if ((state_q == HAZ) && (haz_cycles_q != 32'hFFFF_FFFF)) begin
            haz_cycles_d = haz_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            haz_cycles_q <= '0;
        end else begin
            haz_cycles_q <= haz_cycles_d;
        end
    end

    assign o_haz_cycles = haz_cycles_q;
`endif

endmodule

// File: doc/tl45_operand_fetch.md
Name: tl45_operand_fetch

Overview:
- Parametrised successor register-read stage for the TL45 pipeline, between decode and execute.
- Reads two sources from the DPRF and resolves busy operands from NFWD forwarding buses.
- If an operand cannot be resolved, it stalls upstream and issues bubbles downstream instead of passing unresolved register tags.
- Sets the DPRF busy bit for the destination only on the cycle the instruction actually issues.

Parameters:
- XLEN, 32, datapath and immediate width.
- NREGS, 16, architectural registers including r0; REG_AW = $clog2(NREGS).
- NFWD, 2, number of operand-forwarding buses; lower index has higher priority.
- OPC_W, 5, opcode width; opcode 0 is NOP/bubble.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_pipe_stall  in  1  downstream stall
- o_pipe_stall  out  1  upstream stall = i_pipe_stall | hazard
- i_pipe_flush  in  1  flush request
- o_pipe_flush  out  1  pass-through of i_pipe_flush
- i_opcode  in  OPC_W  decoded opcode
- i_ri  in  1  1 = SR2 replaced by i_imm
- i_dr, i_sr1, i_sr2  in  REG_AW each  register addresses
- i_imm, i_pc  in  XLEN each  immediate and PC
- o_dprf_read_a1, o_dprf_read_a2  out  REG_AW each  = i_sr1, i_sr2 (combinational)
- i_dprf_d1, i_dprf_d2  in  XLEN each  DPRF read data
- o_dprf_setbusy  out  REG_AW  register to mark busy; 0 = none
- i_dprf_busylist  in  NREGS-1  bit k-1 = register k busy
- i_fwd_valid  in  NFWD  bus valid
- i_fwd_reg  in  NFWD*REG_AW  forwarded register tags
- i_fwd_data  in  NFWD*XLEN  forwarded values
- o_opcode  out  OPC_W  registered opcode
- o_dr  out  REG_AW  registered destination
- o_sr1_val, o_sr2_val, o_pc  out  XLEN each  registered operands and PC
- o_hazard  out  1  registered; 1 while in HAZ state

Behaviour:
- Reset: synchronous, active-high. All outputs 0, state = RUN. Reset has priority over flush.
- Flush: on the next edge all output registers clear to 0 and state = RUN. o_dprf_setbusy = 0 in the flush cycle. Flush has priority over stall and hazard.
- Operand resolution, per source s (combinational), in priority order:
  - SR2 with i_ri = 1 → i_imm.
  - s == 0 or busylist[s-1] == 0 → DPRF data.
  - Otherwise the lowest bus j with i_fwd_valid[j] && i_fwd_reg[j] == s → i_fwd_data[j].
  - Otherwise unresolved.
- need_haz = (i_opcode != 0) && (src1 unresolved || src2 unresolved). NOP never hazards.
- State RUN:
  - If i_pipe_stall: hold all outputs.
  - Else if need_haz: load bubble (all outputs 0), go to HAZ.
  - Else: load instruction, stay in RUN.
- State HAZ: re-evaluate every cycle with the same held inputs, since upstream is stalled.
  - If !need_haz and !i_pipe_stall: load instruction, go to RUN.
  - Otherwise: hold bubble, stay in HAZ.
- o_pipe_stall = i_pipe_stall | (need_haz && !i_pipe_flush). Combinational, so the upstream stall asserts in the same cycle the hazard is detected.
- o_dprf_setbusy = i_dr only on an issue cycle (instruction load, not bubble, not flush, not reset) and when opcode is not in IGNORE_DR; otherwise 0.
- Latency: 1 cycle when resolvable; 1 + N cycles when waiting on a writeback N cycles away.
- A forward arriving in the same cycle a busy bit is set is honoured, because forwarding is checked before stalling.

Optional Feature:
- Macro TL45_OPFETCH_PERF_EN.
- Enabled: adds output o_haz_cycles [31:0], counting cycles spent in HAZ. Saturates at 0xFFFFFFFF. Cleared by reset only, not by flush.
- Disabled: port absent, no counter logic.

Decomposition:
- Package tl45_pkg holds:
  - opcode constants OPC_NOP = 5'h00, OPC_JMP = 5'h0C, OPC_LW = 5'h15;
  - IGNORE_DR membership function;
  - state enum {RUN, HAZ}.
- Sub-module tl45_operand_resolve: one combinational instance per source. Outputs value and resolved flag. Parametrised by XLEN, NREGS, NFWD.

Test Plan:
- ADD r3 = r1 + r2 with r1 = 5, r2 = 7, nothing busy → next cycle o_sr1_val = 5, o_sr2_val = 7, o_dr = 3, setbusy = 3 in the issue cycle.
- r1 busy; bus1 = {r1, 0xAA}, bus0 = {r1, 0x55}, both valid → o_sr1_val = 0x55 (bus0 priority), no stall.
- r2 busy, no forwarding for 3 cycles, then bus1 = {r2, 0x1234} → o_pipe_stall high for 3 cycles, 3 bubbles with opcode 0 and setbusy = 0, then issue with o_sr2_val = 0x1234.
- Flush during HAZ → outputs zero, state RUN, o_pipe_flush = 1, setbusy = 0.
- i_ri = 1 with r2 busy, imm = 0xFFFF_FFFE → no stall, o_sr2_val = 0xFFFF_FFFE. LW r4 issue → setbusy = 0.
- i_pipe_stall held 2 cycles while valid → outputs unchanged, o_pipe_stall = 1, setbusy = 0. With PERF_EN, o_haz_cycles is unchanged by these stall cycles.
